// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_if
// Description : Signal bundle between a PWM source/consumer and pwm_capture.
//               SIZE must match the SIZE of the attached pwm_capture.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_capture_if #(
  parameter int SIZE = 12
);
  logic            in;
  logic [SIZE-1:0] period;
  logic [SIZE-1:0] high;
  logic            valid;
  logic            timeout;
  logic            level;
  logic            locked;

  // Side that drives the PWM pin and consumes the measurements
  modport master (
    output in,
    input  period, high, valid, timeout, level, locked
  );

  // Measurement block side
  modport slave (
    input  in,
    output period, high, valid, timeout, level, locked
  );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Samples an asynchronous PWM input and measures its period and
//               high time in clock cycles. One valid strobe per complete
//               period; a timeout strobe when the line stops toggling.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter int SIZE = 12,
  parameter int SYNC = 2   // synchronizer depth, 2..3
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [SIZE-1:0] MAX = '1;
  localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          next_state;
  logic [SYNC-1:0] sync;
  logic            sp;
  logic            s;
  logic            rise;
  logic            fall;
  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] cnt_plus;
  logic [SIZE-1:0] hlatch;
  logic [SIZE-1:0] period;
  logic [SIZE-1:0] high;
  logic            valid;
  logic            timeout;
  logic            valid_nxt;
  logic            timeout_nxt;
  logic            take_fall;

  assign s        = sync[SYNC-1];
  assign rise     = s & ~sp;
  assign fall     = ~s & sp;
  assign cnt_plus = cnt + ONE;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      sp   <= 1'b0;
    end else begin
      sync <= {sync[SYNC-2:0], bus.in};
      sp   <= s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and strobes; a saturated counter wins over a coincident edge
  always_comb begin
    next_state  = state;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    take_fall   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) next_state = HIGH;
      end
      HIGH: begin
        if (cnt == MAX) begin
          next_state  = IDLE;
          timeout_nxt = 1'b1;
        end else if (fall) begin
          next_state = LOW;
          take_fall  = 1'b1;
        end
      end
      LOW: begin
        if (cnt == MAX) begin
          next_state  = IDLE;
          timeout_nxt = 1'b1;
        end else if (rise) begin
          next_state = HIGH;
          valid_nxt  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Cycle counter: restarts on each rise, saturates at MAX, parked at 0 in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               cnt <= '0;
    else if (rise || next_state == IDLE)   cnt <= '0;
    else if (cnt != MAX)                   cnt <= cnt_plus;
  end

  // Measurement registers; period/high hold until the next valid or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hlatch  <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid   <= valid_nxt;
      timeout <= timeout_nxt;
      if (take_fall) hlatch <= cnt_plus;
      if (valid_nxt) begin
        period <= cnt_plus;
        high   <= hlatch;
      end
    end
  end

  assign bus.period  = period;
  assign bus.high    = high;
  assign bus.valid   = valid;
  assign bus.timeout = timeout;
  assign bus.level   = s;
  assign bus.locked  = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture (SIZE=12, SYNC=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture_if #(.SIZE(12)) bus ();

  pwm_capture #(.SIZE(12), .SYNC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Strobe monitor, sampled on the falling edge
  int vcnt = 0, tcnt = 0, both = 0, run = 0, max_run = 0;
  int p_q[$], h_q[$], vc_q[$], tc_q[$];

  always @(negedge clk) begin
    if (bus.valid) begin
      vcnt++;
      p_q.push_back(int'(bus.period));
      h_q.push_back(int'(bus.high));
      vc_q.push_back(cyc);
    end
    if (bus.timeout) begin
      tcnt++;
      tc_q.push_back(cyc);
    end
    if (bus.valid && bus.timeout) both++;
    run = bus.valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold the pin at v for n rising edges (called at a falling edge)
  task automatic drive(input logic v, input int n);
    bus.in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    bus.in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_valid;
    int exp_timeout;
    int exp_period;
    int exp_high;
    int exp_locked;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int vb, tb0, qb, r, r2;

    vecs[0] = '{512,  1536, 2, 2, 0, 2048, 512,  1};
    vecs[1] = '{1024, 1024, 2, 2, 0, 2048, 1024, 1};
    vecs[2] = '{1,    1,    5, 5, 0, 2,    1,    1};
    vecs[3] = '{3,    7,    4, 4, 0, 10,   3,    1};
    vecs[4] = '{100,  3995, 1, 1, 0, 4095, 100,  1};
    vecs[5] = '{4094, 1,    1, 1, 0, 4095, 4094, 1};
    vecs[6] = '{100,  3996, 1, 0, 1, 0,    0,    0};

    bus.in = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_period",  int'(bus.period),  0);
    check("rst_high",    int'(bus.high),    0);
    check("rst_valid",   int'(bus.valid),   0);
    check("rst_timeout", int'(bus.timeout), 0);
    check("rst_level",   int'(bus.level),   0);
    check("rst_locked",  int'(bus.locked),  0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: reps full periods plus a closing rise
    for (int i = 0; i < 7; i++) begin
      do_reset();
      drive(1'b0, 4);
      vb  = vcnt;
      tb0 = tcnt;
      for (int k = 0; k < vecs[i].reps; k++) begin
        drive(1'b1, vecs[i].hi);
        drive(1'b0, vecs[i].lo);
      end
      drive(1'b1, 6);
      check($sformatf("v%0d_valids", i),   vcnt - vb,          vecs[i].exp_valid);
      check($sformatf("v%0d_timeouts", i), tcnt - tb0,         vecs[i].exp_timeout);
      check($sformatf("v%0d_period", i),   int'(bus.period),   vecs[i].exp_period);
      check($sformatf("v%0d_high", i),     int'(bus.high),     vecs[i].exp_high);
      check($sformatf("v%0d_locked", i),   int'(bus.locked),   vecs[i].exp_locked);
      check($sformatf("v%0d_level", i),    int'(bus.level),    1);
    end

    // Pin-to-strobe latency: valid lands 3 edges after the closing pin rise
    do_reset();
    drive(1'b0, 4);
    qb = vc_q.size();
    drive(1'b1, 5);
    drive(1'b0, 5);
    r2 = cyc;
    drive(1'b1, 6);
    check("lat_count",  vc_q.size() - qb, 1);
    check("lat_cycles", (vc_q.size() > qb) ? vc_q[qb] - r2 : -1, 3);
    check("lat_period", int'(bus.period), 10);
    check("lat_high",   int'(bus.high),   5);

    // Duty change 100/200 -> 150/200
    do_reset();
    drive(1'b0, 4);
    qb = p_q.size();
    drive(1'b1, 100); drive(1'b0, 100);
    drive(1'b1, 100); drive(1'b0, 100);
    drive(1'b1, 150); drive(1'b0, 50);
    drive(1'b1, 150); drive(1'b0, 50);
    drive(1'b1, 6);
    check("duty_count", p_q.size() - qb, 4);
    if (p_q.size() - qb == 4) begin
      check("duty_h0", h_q[qb],   100);
      check("duty_h1", h_q[qb+1], 100);
      check("duty_h2", h_q[qb+2], 150);
      check("duty_h3", h_q[qb+3], 150);
      for (int k = 0; k < 4; k++) check("duty_p", p_q[qb+k], 200);
    end

    // Locked, then stuck high: one timeout, measurements retained.
    // The counter restarts on the edge that also registers the valid path,
    // reaches MAX 4095 edges later and the timeout registers one edge after.
    do_reset();
    drive(1'b0, 4);
    vb  = vcnt;
    tb0 = tc_q.size();
    qb  = vc_q.size();
    drive(1'b1, 512);
    drive(1'b0, 1536);
    r = cyc;
    drive(1'b1, 4300);
    check("stuck_valids",   vcnt - vb,          1);
    check("stuck_timeouts", tc_q.size() - tb0,  1);
    if (tc_q.size() - tb0 == 1 && vc_q.size() - qb == 1)
      check("stuck_delay", tc_q[tb0] - vc_q[qb], 4096);
    check("stuck_valid_lat", (vc_q.size() > qb) ? vc_q[qb] - r : -1, 3);
    check("stuck_level",  int'(bus.level),  1);
    check("stuck_locked", int'(bus.locked), 0);
    check("stuck_period", int'(bus.period), 2048);
    check("stuck_high",   int'(bus.high),   512);

    // Constant low from IDLE produces nothing
    do_reset();
    vb  = vcnt;
    tb0 = tcnt;
    drive(1'b0, 4200);
    check("idle_valids",   vcnt - vb,  0);
    check("idle_timeouts", tcnt - tb0, 0);
    check("idle_locked",   int'(bus.locked), 0);

    // Minimum waveform, then asynchronous reset mid-period
    do_reset();
    drive(1'b0, 4);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b1, 1);
    check("min_period", int'(bus.period), 2);
    check("min_high",   int'(bus.high),   1);
    check("min_locked", int'(bus.locked), 1);
    bus.in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_period",  int'(bus.period),  0);
    check("arst_high",    int'(bus.high),    0);
    check("arst_valid",   int'(bus.valid),   0);
    check("arst_timeout", int'(bus.timeout), 0);
    check("arst_level",   int'(bus.level),   0);
    check("arst_locked",  int'(bus.locked),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3);
    qb = vc_q.size();
    r  = cyc;
    drive(1'b1, 1); drive(1'b0, 1);
    drive(1'b1, 1); drive(1'b0, 1);
    drive(1'b1, 1); drive(1'b0, 4);
    check("post_rst_count", vc_q.size() - qb, 2);
    check("post_rst_first", (vc_q.size() > qb) ? vc_q[qb] - r : -1, 5);
    check("post_rst_period", int'(bus.period), 2);

    // Global strobe properties
    check("valid_and_timeout", both, 0);
    check("valid_width", max_run, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the pwm generator: samples an external PWM waveform on the system clock and measures its period and high time in clock cycles.
- Each completed period (rising edge to next rising edge) yields a 1-cycle valid strobe with the result.
- Used to read back PWM (e.g. pwm on gp[0] driven from div8_clk) and external step/PWM signals in the stepper design.
- Detects a stuck line (0 %/100 % duty, or a period too long to represent) and reports it.

Parameters:
- SIZE, 12: width of the period/high counters and outputs. Maximum measurable period is 2^SIZE-1 cycles.
- SYNC, 2: number of input synchronizer flops. Legal range is 2..3.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  asynchronous PWM input.
- period  output  SIZE  cycles from rising edge to next rising edge of the last complete period.
- high  output  SIZE  cycles the input was high in that period.
- valid  output  1  1-cycle strobe; period/high updated this cycle.
- timeout  output  1  1-cycle strobe; no edge for 2^SIZE-1 cycles.
- level  output  1  synchronized input level; meaningful as stuck level when timeout fires.
- locked  output  1  high while in HIGH or LOW state.

Behaviour:
- Reset (async assert, sync release): all sync flops, counters, period, high, valid, timeout, level and locked go to 0; state goes to IDLE.
- Synchronizer: in passes through SYNC flops giving s. The previous value is sp.
  - rise = s & ~sp; fall = ~s & sp.
  - level = s.
- Counter cnt (SIZE bits):
  - Loads 0 on a clock with rise.
  - Otherwise increments by 1 and saturates at MAX = 2^SIZE-1.
  - In IDLE it is held at 0.
- States:
  - IDLE:
    - rise -> HIGH, with no output.
    - Otherwise stay.
  - HIGH:
    - cnt==MAX -> IDLE and pulse timeout. Timeout has priority over a simultaneous fall.
    - Else fall -> LOW, and hlatch <= cnt+1.
  - LOW:
    - cnt==MAX -> IDLE and pulse timeout. Priority over a simultaneous rise.
    - Else rise -> HIGH, with period <= cnt+1, high <= hlatch, valid=1 for one cycle.
- Latency: a pin edge that meets setup before clock edge k shows up as valid/timeout/locked updates registered at edge k+SYNC. With SYNC=2 that is 3 clock edges from pin to strobe.
- The first rise after IDLE/reset never produces valid; the first valid arrives after one complete period.
- period and high hold their values between strobes, including across timeout. Only reset clears them.
- valid and timeout are never high in the same cycle.
- Minimum measurable waveform is 1 cycle high, 1 cycle low (period=2, high=1), provided the input meets synchronizer sampling.
- Period P ≤ MAX gives valid. P ≥ 2^SIZE gives timeout, and timeout repeats each time the state machine relocks and starves again.
- A constant input produces one timeout per MAX cycles only after having locked. From IDLE, a constant input produces nothing.
- Glitches shorter than a clock may be missed; no filtering is done.
- rst asserted mid-period aborts the measurement immediately. After release, the block waits in IDLE for the next rise.

Test Plan:
1. SIZE=12, SYNC=2: reset, then drive 512 cycles high / 1536 low, repeated 3 periods -> first valid only at the second rise; each valid shows period=2048, high=512. valid is 1 cycle wide, landing 3 cycles after the pin rise.
2. pwm SIZE=8 with set=128, clocked at clk/8, feeding in -> valid every 2048 cycles with period=2048, high=1024, locked=1 from the first rise.
3. Duty change mid-stream from 100/200 to 150/200 (high/period) -> the next valid reports high=100. The one after reports high=150, with period=200 throughout.
4. After locking, hold in high -> timeout pulses when cnt hits 4095, i.e. 4095 cycles after the last rise. level=1, locked=0, period/high retain their last values, no valid.
5. Boundary: period 4095 gives valid with period=4095. Period 4096 gives timeout and no valid.
6. Minimum waveform 1 high / 1 low -> valid every 2 cycles with period=2, high=1. Assert rst mid-period -> all outputs 0 immediately. After release, the next valid arrives only after a full period following the first rise.
